// File: rtl/sram_arbiter.sv
// Round-robin arbiter for two masters sharing one 16-bit SRAM bus.
// Each access runs as SETUP, STROBE (STROBE_CYCLES long), then HOLD.
module sram_arbiter #(
    parameter int unsigned STROBE_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        p0_req,
    input  logic        p1_req,
    input  logic        p0_write,
    input  logic        p1_write,
    input  logic [15:0] p0_addr,
    input  logic [15:0] p1_addr,
    input  logic [15:0] p0_wdata,
    input  logic [15:0] p1_wdata,
    output logic        p0_ack,
    output logic        p1_ack,
    output logic [15:0] p0_rdata,
    output logic [15:0] p1_rdata,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_write,
    input  logic [15:0] mem_rdata,
    output logic        busy,
    output logic [1:0]  grant
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t      state_q;
    logic        last_q;
    logic [3:0]  cnt_q;
    logic        wr_q;
    logic [1:0]  grant_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        mem_write_q;
    logic        p0_ack_q;
    logic        p1_ack_q;
    logic [15:0] p0_rdata_q;
    logic [15:0] p1_rdata_q;

    logic        req_any_d;
    logic        pick_d;

    // On a tie the port not served last wins; otherwise the sole requester.
    always_comb begin
        req_any_d = p0_req | p1_req;
        if (p0_req && p1_req) begin
            pick_d = ~last_q;
        end else begin
            pick_d = p1_req;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            grant_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_write_q <= 1'b0;
            p0_ack_q    <= 1'b0;
            p1_ack_q    <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            p0_ack_q <= 1'b0;
            p1_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_any_d) begin
                        state_q <= SETUP;
                        last_q  <= pick_d;
                        grant_q <= pick_d ? 2'b10 : 2'b01;
                        addr_q  <= pick_d ? p1_addr  : p0_addr;
                        wdata_q <= pick_d ? p1_wdata : p0_wdata;
                        wr_q    <= pick_d ? p1_write : p0_write;
                    end
                end
                SETUP: begin
                    state_q     <= STROBE;
                    cnt_q       <= STROBE_CYCLES[3:0];
                    mem_write_q <= wr_q;
                end
                STROBE: begin
                    if (cnt_q == 4'd1) begin
                        // Last strobe edge: close the strobe, capture read data, raise ack.
                        state_q     <= HOLD;
                        mem_write_q <= 1'b0;
                        if (!wr_q) begin
                            if (grant_q[1]) begin
                                p1_rdata_q <= mem_rdata;
                            end else begin
                                p0_rdata_q <= mem_rdata;
                            end
                        end
                        p0_ack_q <= grant_q[0];
                        p1_ack_q <= grant_q[1];
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                HOLD: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign p0_ack    = p0_ack_q;
    assign p1_ack    = p1_ack_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_write = mem_write_q;
    assign busy      = (state_q != IDLE);
    assign grant     = grant_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus random traffic, checked
// cycle by cycle against a transaction-phase reference model.
module tb_sram_arbiter;

    localparam int S = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic        p0_req, p1_req, p0_write, p1_write;
    logic [15:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
    logic        p0_ack, p1_ack;
    logic [15:0] p0_rdata, p1_rdata;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_write, busy;
    logic [1:0]  grant;

    // Extra builds with minimum and maximum strobe length
    logic        x1_req, x15_req;
    logic        x1_ack, x15_ack, x1_ack1, x15_ack1;
    logic [15:0] x1_rd0, x1_rd1, x15_rd0, x15_rd1;
    logic [15:0] x1_addr, x1_wdata, x15_addr, x15_wdata;
    logic        x1_mw, x15_mw, x1_busy, x15_busy;
    logic [1:0]  x1_grant, x15_grant;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: phase 0 = idle, 1 = setup, 2..S+1 = strobe, S+2 = hold
    int          m_phase = 0;
    int          m_owner = 0;
    int          m_last  = 1;
    logic [15:0] m_addr  = '0;
    logic [15:0] m_wdata = '0;
    bit          m_wr    = 1'b0;
    logic [15:0] m_rdata [2];

    always #5 CLK = ~CLK;

    function automatic logic [15:0] memf(input logic [15:0] a);
        return (a == 16'h0100) ? 16'hBEEF : (a ^ 16'h5A3C);
    endfunction

    always_comb mem_rdata = memf(mem_addr);

    sram_arbiter #(.STROBE_CYCLES(S)) dut (
        .CLK(CLK), .RST(RST),
        .p0_req(p0_req), .p1_req(p1_req),
        .p0_write(p0_write), .p1_write(p1_write),
        .p0_addr(p0_addr), .p1_addr(p1_addr),
        .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
        .p0_ack(p0_ack), .p1_ack(p1_ack),
        .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .mem_rdata(mem_rdata),
        .busy(busy), .grant(grant)
    );

    sram_arbiter #(.STROBE_CYCLES(1)) dut_s1 (
        .CLK(CLK), .RST(RST),
        .p0_req(x1_req), .p1_req(1'b0),
        .p0_write(1'b1), .p1_write(1'b0),
        .p0_addr(16'h0011), .p1_addr(16'h0000),
        .p0_wdata(16'hAAAA), .p1_wdata(16'h0000),
        .p0_ack(x1_ack), .p1_ack(x1_ack1),
        .p0_rdata(x1_rd0), .p1_rdata(x1_rd1),
        .mem_addr(x1_addr), .mem_wdata(x1_wdata),
        .mem_write(x1_mw), .mem_rdata(16'h0000),
        .busy(x1_busy), .grant(x1_grant)
    );

    sram_arbiter #(.STROBE_CYCLES(15)) dut_s15 (
        .CLK(CLK), .RST(RST),
        .p0_req(x15_req), .p1_req(1'b0),
        .p0_write(1'b1), .p1_write(1'b0),
        .p0_addr(16'h0022), .p1_addr(16'h0000),
        .p0_wdata(16'h5555), .p1_wdata(16'h0000),
        .p0_ack(x15_ack), .p1_ack(x15_ack1),
        .p0_rdata(x15_rd0), .p1_rdata(x15_rd1),
        .mem_addr(x15_addr), .mem_wdata(x15_wdata),
        .mem_write(x15_mw), .mem_rdata(16'h0000),
        .busy(x15_busy), .grant(x15_grant)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit exp_ack(input int p);
        return (m_phase == S + 2) && (m_owner == p);
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        if (RST) begin
            m_phase = 0; m_owner = 0; m_last = 1;
            m_addr = '0; m_wdata = '0; m_wr = 1'b0;
            m_rdata[0] = '0; m_rdata[1] = '0;
        end else if (m_phase == 0) begin
            if (p0_req || p1_req) begin
                if (p0_req && p1_req) m_owner = (m_last == 1) ? 0 : 1;
                else                  m_owner = p1_req ? 1 : 0;
                m_last  = m_owner;
                m_phase = 1;
                m_addr  = (m_owner == 1) ? p1_addr  : p0_addr;
                m_wdata = (m_owner == 1) ? p1_wdata : p0_wdata;
                m_wr    = (m_owner == 1) ? p1_write : p0_write;
            end
        end else begin
            if (m_phase == S + 1 && !m_wr) m_rdata[m_owner] = memf(m_addr);
            m_phase = (m_phase == S + 2) ? 0 : m_phase + 1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        @(negedge CLK);
        cyc++;
        check("busy",      32'(busy),      32'(m_phase != 0));
        check("grant",     32'(grant),     (m_phase == 0) ? 32'd0 : ((m_owner == 1) ? 32'd2 : 32'd1));
        check("mem_write", 32'(mem_write), 32'(m_wr && m_phase >= 2 && m_phase <= S + 1));
        check("p0_ack",    32'(p0_ack),    32'(exp_ack(0)));
        check("p1_ack",    32'(p1_ack),    32'(exp_ack(1)));
        check("mem_addr",  32'(mem_addr),  32'(m_addr));
        check("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
        check("p0_rdata",  32'(p0_rdata),  32'(m_rdata[0]));
        check("p1_rdata",  32'(p1_rdata),  32'(m_rdata[1]));
    endtask

    initial begin
        int order[$];
        int ack_cyc[$];
        int done[2];
        bit pend[2];
        int wr1, wr15, ack1, ack15;

        m_rdata[0] = '0; m_rdata[1] = '0;
        x1_req = 1'b0; x15_req = 1'b0;

        // Reset with both ports requesting
        RST = 1'b1;
        p0_req = 1'b1; p0_write = 1'b1; p0_addr = 16'h0001; p0_wdata = 16'h0A0A;
        p1_req = 1'b1; p1_write = 1'b1; p1_addr = 16'h0002; p1_wdata = 16'h0B0B;
        tick();
        tick();
        RST = 1'b0;
        tick();
        check("first_grant", 32'(grant), 32'd1);
        p0_req = 1'b0; p1_req = 1'b0;
        repeat (S + 3) tick();

        // Single write from port 0
        p0_req = 1'b1; p0_write = 1'b1; p0_addr = 16'h0040; p0_wdata = 16'h1234;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("wr_strobe", 32'(mem_write), 32'(k >= 2 && k <= S + 1));
            check("wr_ack",    32'(p0_ack),    32'(k == S + 2));
            if (k <= S + 2) begin
                check("wr_addr",  32'(mem_addr),  32'h0040);
                check("wr_wdata", 32'(mem_wdata), 32'h1234);
            end
            if (k == S + 2) p0_req = 1'b0;
        end

        // Single read from port 1
        p1_req = 1'b1; p1_write = 1'b0; p1_addr = 16'h0100;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("rd_nowrite", 32'(mem_write), 32'd0);
            check("rd_ack",     32'(p1_ack),    32'(k == S + 2));
            if (k == S + 2) begin
                check("rd_data", 32'(p1_rdata), 32'hBEEF);
                p1_req = 1'b0;
            end
        end

        // Contention: both ports read continuously, four accesses each
        done[0] = 0; done[1] = 0;
        p0_req = 1'b1; p0_write = 1'b0; p0_addr = 16'($urandom);
        p1_req = 1'b1; p1_write = 1'b0; p1_addr = 16'($urandom);
        for (int t = 0; t < 200 && (done[0] < 4 || done[1] < 4); t++) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                if (exp_ack(p)) begin
                    order.push_back(p);
                    ack_cyc.push_back(cyc);
                    done[p]++;
                    if (p == 0) begin
                        if (done[0] < 4) p0_addr = 16'($urandom); else p0_req = 1'b0;
                    end else begin
                        if (done[1] < 4) p1_addr = 16'($urandom); else p1_req = 1'b0;
                    end
                end
            end
        end
        check("cont_count", 32'(order.size()), 32'd8);
        for (int i = 0; i < order.size(); i++) begin
            check("cont_order", 32'(order[i]), 32'(i % 2));
            if (i > 0) check("cont_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'(S + 3));
        end
        p0_req = 1'b0; p1_req = 1'b0;
        repeat (S + 3) tick();

        // Reset in the first strobe cycle of a write
        p0_req = 1'b1; p0_write = 1'b1; p0_addr = 16'h0222; p0_wdata = 16'h5555;
        tick();
        tick();
        check("pre_rst_strobe", 32'(mem_write), 32'd1);
        RST = 1'b1;
        tick();
        check("rst_mw", 32'(mem_write), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        RST = 1'b0; p0_req = 1'b0;
        repeat (S + 4) tick();

        // Random traffic with occasional resets and mid-access request drops
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int t = 0; t < 600; t++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        pend[p] = 1'b1;
                        if (p == 0) begin
                            p0_req = 1'b1; p0_write = 1'($urandom);
                            p0_addr = 16'($urandom); p0_wdata = 16'($urandom);
                        end else begin
                            p1_req = 1'b1; p1_write = 1'($urandom);
                            p1_addr = 16'($urandom); p1_wdata = 16'($urandom);
                        end
                    end
                end else if (m_phase != 0 && m_owner == p && $urandom_range(0, 7) == 0) begin
                    if (p == 0) p0_req = 1'b0; else p1_req = 1'b0;
                end
            end
            RST = ($urandom_range(0, 99) == 0);
            tick();
            if (RST) begin
                pend[0] = 1'b0; pend[1] = 1'b0;
                p0_req = 1'b0; p1_req = 1'b0;
            end
            for (int p = 0; p < 2; p++) begin
                if (exp_ack(p)) begin
                    pend[p] = 1'b0;
                    if (p == 0) p0_req = 1'b0; else p1_req = 1'b0;
                end
            end
        end
        RST = 1'b0; p0_req = 1'b0; p1_req = 1'b0;
        repeat (S + 3) tick();

        // Strobe length extremes: single write on the 1- and 15-cycle builds
        wr1 = 0; wr15 = 0; ack1 = 0; ack15 = 0;
        x1_req = 1'b1; x15_req = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (x1_mw)  wr1++;
            if (x15_mw) wr15++;
            if (x1_ack  && ack1  == 0) ack1  = k;
            if (x15_ack && ack15 == 0) ack15 = k;
            if (k == 3)  x1_req  = 1'b0;
            if (k == 17) x15_req = 1'b0;
        end
        check("s1_strobe_len",  32'(wr1),   32'd1);
        check("s1_ack_cycle",   32'(ack1),  32'd3);
        check("s15_strobe_len", 32'(wr15),  32'd15);
        check("s15_ack_cycle",  32'(ack15), 32'd17);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
